// File: rtl/adder_share_arb.sv
// -----------------------------------------------------------------------------
// adder_share_arb
//   Shares a single ripple-carry adderN between two requesters.
//   A round-robin arbiter picks a winner in IDLE, its operands are captured,
//   the addition runs in EXEC, and the registered sum/carry is presented with
//   a one-cycle done pulse in RESP.
//
//   Optional build macro:
//     ADDER_ARB_SAT_EN  - when the adder carries out, the registered sum is
//                         forced to all-ones. cout still reports the carry.
//                         When it is undefined, the sum wraps.
// -----------------------------------------------------------------------------

// Plain N-bit ripple-carry adder built from full-adder cells.
module adderN #(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);

  logic [N:0] carry;

  assign carry[0] = cin;

  for (genvar i = 0; i < N; i++) begin : g_fa
    assign sum[i]     = a[i] ^ b[i] ^ carry[i];
    assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
  end

  assign cout = carry[N];

endmodule


module adder_share_arb #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0,
  input  logic [N-1:0] a0,
  input  logic [N-1:0] b0,
  input  logic         req1,
  input  logic [N-1:0] a1,
  input  logic [N-1:0] b1,
  output logic         gnt0,
  output logic         gnt1,
  output logic         done,
  output logic         done_id,
  output logic [N-1:0] sum,
  output logic         cout
  ,
  output logic         busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t       state;
  state_t       state_nx;

  logic         take;      // a grant happens at the coming edge
  logic         win_sel;   // arbiter choice for the coming grant
  logic         win;       // owner of the operation in flight
  logic         last;      // most recent winner, drives the round-robin tie-break

  logic [N-1:0] op_a;
  logic [N-1:0] op_b;

  logic [N-1:0] add_sum;
  logic         add_cout;
  logic [N-1:0] res_sum;

  // Round-robin choice: a lone request wins; on a tie the port that did not
  // win last time goes first.
  always_comb begin
    if (req0 && req1) begin
      win_sel = ~last;
    end else begin
      win_sel = req1;
    end
  end

  // Next-state logic for the fixed IDLE -> EXEC -> RESP sequence.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path can leave
    // it unassigned, which would otherwise infer a latch.
    state_nx = state;
    take     = 1'b0;
    unique case (state)
      IDLE: begin
        if (req0 || req1) begin
          take     = 1'b1;
          state_nx = EXEC;
        end
      end
      EXEC:    state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state is always written with non-blocking assignments
    // so every register samples pre-edge values regardless of block ordering.
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Capture the winner and its operands on a grant; the adder inputs stay
  // frozen otherwise, so requester activity during EXEC/RESP is ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last <= 1'b1;
      win  <= 1'b0;
      op_a <= '0;
      op_b <= '0;
    end else if (take) begin
      last <= win_sel;
      win  <= win_sel;
      op_a <= win_sel ? a1 : a0;
      op_b <= win_sel ? b1 : b0;
    end
  end

  // The single shared adder.
  adderN #(.N(N)) u_adder (
    .a    (op_a),
    .b    (op_b),
    .cin  (1'b0),
    .sum  (add_sum),
    .cout (add_cout)
  );

`ifdef ADDER_ARB_SAT_EN
  // Clamp to all-ones when the addition overflows N bits.
  assign res_sum = add_cout ? {N{1'b1}} : add_sum;
`else
  // Raw wrapping sum.
  assign res_sum = add_sum;
`endif

  // Register the result at the end of EXEC; it holds until the next done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum     <= '0;
      cout    <= 1'b0;
      done_id <= 1'b0;
    end else if (state == EXEC) begin
      sum     <= res_sum;
      cout    <= add_cout;
      done_id <= win;
    end
  end

  // Status pulses decode directly from the state register, so reset clears
  // them immediately and an aborted operation never reports done.
  assign gnt0 = (state == EXEC) && !win;
  assign gnt1 = (state == EXEC) &&  win;
  assign done = (state == RESP);
  assign busy = (state != IDLE);

endmodule
